// File: rtl/dmem_access_seq_if.sv
// dmem_access_seq_if: bundles the MEM-stage request/response and the data-memory bus.
//   req_*      pipeline request (valid, we, addr, wdata, funct3)
//   stall/rsp_* pipeline freeze and completion response (valid, rdata, err)
//   mem_*      word-wide byte-strobed memory port (en, we, addr, wstrb, wdata, rdata)
//   slave  = the sequencer, master = pipeline + memory environment
interface dmem_access_seq_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
        output stall, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/dmem_access_seq.sv
// dmem_access_seq: sequences MEM-stage loads/stores onto a 1-cycle-latency byte-strobed memory,
// splitting word-crossing accesses into two aligned words and returning extended load data.
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   io   dmem_access_seq_if.slave (request, stall/response, memory bus)
module dmem_access_seq #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic            clk,
    input logic            rst,
    dmem_access_seq_if.slave io
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t      state;
    logic [31:0] a_q;
    logic [31:0] wd_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [3:0]  mask_q;
    logic        cross_q;
    logic [31:0] lo_q;
    logic [1:0]  off_i;
    logic [3:0]  mask_i;
    logic        cross_i;
    logic        bad_i;
    logic [2:0]  hi_sh;
    logic [63:0] cat;
    logic [31:0] sh;
    logic [31:0] ext;
    always_comb begin
        off_i   = io.req_addr[1:0];
        mask_i  = io.req_funct3[1] ? 4'b1111 : io.req_funct3[0] ? 4'b0011 : 4'b0001;
        cross_i = io.req_funct3[1] ? |off_i : io.req_funct3[0] & (&off_i);
        // funct3 011, 110 and 111 are the illegal encodings
        bad_i   = (io.req_funct3[1] & (io.req_funct3[0] | io.req_funct3[2])) | (cross_i & !ALLOW_MISALIGNED);
        // second word of a split access carries the bytes above the word boundary
        hi_sh   = 3'd4 - {1'b0, a_q[1:0]};
        cat     = cross_q ? {io.mem_rdata, lo_q} : {32'd0, io.mem_rdata};
        sh      = 32'(cat >> {a_q[1:0], 3'b000});
        ext     = f3_q[1] ? sh :
                  f3_q[0] ? {{16{sh[15] & !f3_q[2]}}, sh[15:0]} :
                            {{24{sh[7] & !f3_q[2]}}, sh[7:0]};
    end
    assign io.stall     = ((state == IDLE) & io.req_valid) | (state == ACC0) | (state == ACC1);
    assign io.rsp_rdata = (io.rsp_valid & !io.rsp_err & !we_q) ? ext : 32'd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            a_q          <= '0;
            wd_q         <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            mask_q       <= '0;
            cross_q      <= 1'b0;
            lo_q         <= '0;
            io.rsp_valid <= 1'b0;
            io.rsp_err   <= 1'b0;
            io.mem_en    <= 1'b0;
            io.mem_we    <= 1'b0;
            io.mem_addr  <= '0;
            io.mem_wstrb <= '0;
            io.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (io.req_valid) begin
                    a_q     <= io.req_addr;
                    wd_q    <= io.req_wdata;
                    f3_q    <= io.req_funct3;
                    we_q    <= io.req_we;
                    mask_q  <= mask_i;
                    cross_q <= cross_i;
                    if (bad_i) begin
                        state        <= RESP;
                        io.rsp_valid <= 1'b1;
                        io.rsp_err   <= 1'b1;
                    end else begin
                        state        <= ACC0;
                        io.mem_en    <= 1'b1;
                        io.mem_we    <= io.req_we;
                        io.mem_addr  <= {io.req_addr[31:2], 2'b00};
                        io.mem_wstrb <= mask_i << off_i;
                        io.mem_wdata <= io.req_wdata << {off_i, 3'b000};
                    end
                end
                ACC0: if (cross_q) begin
                    state        <= ACC1;
                    io.mem_addr  <= {a_q[31:2] + 30'd1, 2'b00};
                    io.mem_wstrb <= mask_q >> hi_sh;
                    io.mem_wdata <= wd_q >> {hi_sh, 3'b000};
                end else begin
                    state        <= RESP;
                    io.mem_en    <= 1'b0;
                    io.mem_we    <= 1'b0;
                    io.mem_wstrb <= '0;
                    io.rsp_valid <= 1'b1;
                end
                ACC1: begin
                    lo_q         <= io.mem_rdata;
                    state        <= RESP;
                    io.mem_en    <= 1'b0;
                    io.mem_we    <= 1'b0;
                    io.mem_wstrb <= '0;
                    io.rsp_valid <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    io.rsp_valid <= 1'b0;
                    io.rsp_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_seq.sv
// tb_dmem_access_seq: directed-vector bench for dmem_access_seq with a small byte-strobed memory.
module tb_dmem_access_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    dmem_access_seq_if io();
    dmem_access_seq_if io2();
    dmem_access_seq #(.ALLOW_MISALIGNED(1'b1)) dut  (.clk(clk), .rst(rst), .io(io.slave));
    dmem_access_seq #(.ALLOW_MISALIGNED(1'b0)) dut2 (.clk(clk), .rst(rst), .io(io2.slave));
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (io.mem_en) begin
            io.mem_rdata <= mem[io.mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (io.mem_we && io.mem_wstrb[b]) mem[io.mem_addr[9:2]][8*b +: 8] = io.mem_wdata[8*b +: 8];
        end
    end
    int          n_acc, rsp_cyc;
    logic [31:0] a_addr [2];
    logic [31:0] a_wdata [2];
    logic [3:0]  a_wstrb [2];
    logic        a_we [2];
    logic [31:0] r_rdata;
    logic        r_err, r_stall, s1;
    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        io.req_valid = 1'b1; io.req_we = we; io.req_addr = addr; io.req_wdata = wd; io.req_funct3 = f3;
        n_acc = 0; rsp_cyc = 0; s1 = 1'b0; r_rdata = 'x; r_err = 1'bx; r_stall = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (k == 1) s1 = io.stall;
            if (io.mem_en) begin
                if (n_acc < 2) begin
                    a_addr[n_acc] = io.mem_addr; a_wdata[n_acc] = io.mem_wdata;
                    a_wstrb[n_acc] = io.mem_wstrb; a_we[n_acc] = io.mem_we;
                end
                n_acc++;
            end
            if (io.rsp_valid) begin
                rsp_cyc = k; r_rdata = io.rsp_rdata; r_err = io.rsp_err; r_stall = io.stall;
                break;
            end
            @(negedge clk);
        end
        io.req_valid = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_reset();
        checks++; if (io.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", io.stall); end
        checks++; if (io.rsp_valid !== 1'b0 || io.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b/%b want 0/0", io.rsp_valid, io.rsp_err); end
        checks++; if (io.mem_en !== 1'b0 || io.mem_we !== 1'b0 || io.mem_wstrb !== 4'b0) begin errors++; $display("FAIL reset_mem got en=%b we=%b strb=%b want 0 0 0000", io.mem_en, io.mem_we, io.mem_wstrb); end
        checks++; if (io.mem_addr !== 32'h0 || io.mem_wdata !== 32'h0 || io.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h want zeros", io.mem_addr, io.mem_wdata, io.rsp_rdata); end
    endtask
    task automatic test_load_aligned();
        mem[64] = 32'h8899AABB;
        run(1'b0, 32'h100, 32'h0, 3'b010);
        checks++; if (s1 !== 1'b1) begin errors++; $display("FAIL lw_stall_req got %b want 1", s1); end
        checks++; if (n_acc != 1 || a_addr[0] !== 32'h100) begin errors++; $display("FAIL lw_acc got n=%0d addr=%h want 1 00000100", n_acc, a_addr[0]); end
        checks++; if (rsp_cyc != 3) begin errors++; $display("FAIL lw_latency got %0d want 3", rsp_cyc); end
        checks++; if (r_rdata !== 32'h8899AABB || r_err !== 1'b0) begin errors++; $display("FAIL lw_data got %h err=%b want 8899aabb err=0", r_rdata, r_err); end
        checks++; if (r_stall !== 1'b0) begin errors++; $display("FAIL lw_stall_rsp got %b want 0", r_stall); end
    endtask
    logic [31:0] t_addr [8] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h100, 32'h103, 32'h101, 32'h103};
    logic [2:0]  t_f3   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b001, 3'b010, 3'b010};
    logic [31:0] t_exp  [8] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                32'hFFFFAABB, 32'h00004488, 32'h448899AA, 32'h22334488};
    int          t_cyc  [8] = '{3, 3, 3, 3, 3, 4, 4, 4};
    task automatic test_load_ext();
        mem[64] = 32'h8899AABB; mem[65] = 32'h11223344;
        for (int i = 0; i < 8; i++) begin
            run(1'b0, t_addr[i], 32'h0, t_f3[i]);
            checks++; if (r_rdata !== t_exp[i] || rsp_cyc != t_cyc[i]) begin errors++; $display("FAIL load_ext[%0d] got %h cyc=%0d want %h cyc=%0d", i, r_rdata, rsp_cyc, t_exp[i], t_cyc[i]); end
        end
    endtask
    task automatic test_load_cross();
        mem[64] = 32'h80112233; mem[65] = 32'h445566FF;
        run(1'b0, 32'h103, 32'h0, 3'b001);
        checks++; if (n_acc != 2 || a_addr[0] !== 32'h100 || a_addr[1] !== 32'h104) begin errors++; $display("FAIL lh_cross_acc got n=%0d %h %h want 2 00000100 00000104", n_acc, a_addr[0], a_addr[1]); end
        checks++; if (r_rdata !== 32'hFFFFFF80 || rsp_cyc != 4) begin errors++; $display("FAIL lh_cross got %h cyc=%0d want ffffff80 cyc=4", r_rdata, rsp_cyc); end
        run(1'b0, 32'h103, 32'h0, 3'b101);
        checks++; if (r_rdata !== 32'h0000FF80) begin errors++; $display("FAIL lhu_cross got %h want 0000ff80", r_rdata); end
    endtask
    task automatic test_store_cross();
        mem[64] = 32'h80112233; mem[65] = 32'h445566FF;
        run(1'b1, 32'h102, 32'hDEADBEEF, 3'b010);
        checks++; if (n_acc != 2 || a_we[0] !== 1'b1 || a_we[1] !== 1'b1) begin errors++; $display("FAIL sw_cross_n got n=%0d we=%b%b want 2 11", n_acc, a_we[0], a_we[1]); end
        checks++; if (a_addr[0] !== 32'h100 || a_wstrb[0] !== 4'b1100 || a_wdata[0] !== 32'hBEEF0000) begin errors++; $display("FAIL sw_acc0 got %h %b %h want 00000100 1100 beef0000", a_addr[0], a_wstrb[0], a_wdata[0]); end
        checks++; if (a_addr[1] !== 32'h104 || a_wstrb[1] !== 4'b0011 || a_wdata[1] !== 32'h0000DEAD) begin errors++; $display("FAIL sw_acc1 got %h %b %h want 00000104 0011 0000dead", a_addr[1], a_wstrb[1], a_wdata[1]); end
        checks++; if (r_rdata !== 32'h0 || rsp_cyc != 4) begin errors++; $display("FAIL sw_rsp got %h cyc=%0d want 0 cyc=4", r_rdata, rsp_cyc); end
        checks++; if (mem[64] !== 32'hBEEF2233 || mem[65] !== 32'h4455DEAD) begin errors++; $display("FAIL sw_mem got %h %h want beef2233 4455dead", mem[64], mem[65]); end
        run(1'b0, 32'h102, 32'h0, 3'b010);
        checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback got %h want deadbeef", r_rdata); end
        run(1'b1, 32'h101, 32'h123456A5, 3'b000);
        checks++; if (n_acc != 1 || a_wstrb[0] !== 4'b0010 || a_wdata[0] !== 32'h3456A500) begin errors++; $display("FAIL sb got n=%0d %b %h want 1 0010 3456a500", n_acc, a_wstrb[0], a_wdata[0]); end
        run(1'b1, 32'h103, 32'h0000CAFE, 3'b001);
        checks++; if (a_wstrb[0] !== 4'b1000 || a_wdata[0] !== 32'hFE000000 || a_wstrb[1] !== 4'b0001 || a_wdata[1] !== 32'h000000CA) begin errors++; $display("FAIL sh_cross got %b %h %b %h want 1000 fe000000 0001 000000ca", a_wstrb[0], a_wdata[0], a_wstrb[1], a_wdata[1]); end
    endtask
    task automatic test_store_wrap();
        run(1'b1, 32'hFFFFFFFE, 32'h12345678, 3'b010);
        checks++; if (a_addr[0] !== 32'hFFFFFFFC || a_wstrb[0] !== 4'b1100 || a_wdata[0] !== 32'h56780000) begin errors++; $display("FAIL wrap_acc0 got %h %b %h want fffffffc 1100 56780000", a_addr[0], a_wstrb[0], a_wdata[0]); end
        checks++; if (a_addr[1] !== 32'h0 || a_wstrb[1] !== 4'b0011 || a_wdata[1] !== 32'h00001234) begin errors++; $display("FAIL wrap_acc1 got %h %b %h want 00000000 0011 00001234", a_addr[1], a_wstrb[1], a_wdata[1]); end
    endtask
    task automatic test_error();
        run(1'b0, 32'h100, 32'h0, 3'b011);
        checks++; if (n_acc != 0 || rsp_cyc != 2 || r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL err_011 got n=%0d cyc=%0d err=%b data=%h want 0 2 1 0", n_acc, rsp_cyc, r_err, r_rdata); end
        run(1'b1, 32'h100, 32'hFFFFFFFF, 3'b111);
        checks++; if (n_acc != 0 || rsp_cyc != 2 || r_err !== 1'b1) begin errors++; $display("FAIL err_111 got n=%0d cyc=%0d err=%b want 0 2 1", n_acc, rsp_cyc, r_err); end
    endtask
    logic [31:0] nm_addr [2] = '{32'h101, 32'h100};
    logic        nm_err  [2] = '{1'b1, 1'b0};
    int          nm_cyc  [2] = '{2, 3};
    task automatic test_no_misalign();
        int n, c;
        logic e;
        for (int i = 0; i < 2; i++) begin
            io2.req_valid = 1'b1; io2.req_we = 1'b0; io2.req_addr = nm_addr[i]; io2.req_funct3 = 3'b010;
            n = 0; c = 0; e = 1'bx;
            for (int k = 1; k <= 8; k++) begin
                #1;
                if (io2.mem_en) n++;
                if (io2.rsp_valid) begin c = k; e = io2.rsp_err; break; end
                @(negedge clk);
            end
            io2.req_valid = 1'b0;
            @(negedge clk);
            checks++; if (n != (nm_err[i] ? 0 : 1) || c != nm_cyc[i] || e !== nm_err[i]) begin errors++; $display("FAIL no_misalign[%0d] got n=%0d cyc=%0d err=%b want n=%0d cyc=%0d err=%b", i, n, c, e, nm_err[i] ? 0 : 1, nm_cyc[i], nm_err[i]); end
        end
    endtask
    task automatic test_back_to_back();
        mem[64] = 32'hCAFEF00D;
        run(1'b0, 32'h100, 32'h0, 3'b010);
        checks++; if (r_rdata !== 32'hCAFEF00D || rsp_cyc != 3) begin errors++; $display("FAIL b2b_lw got %h cyc=%0d want cafef00d 3", r_rdata, rsp_cyc); end
        run(1'b0, 32'h103, 32'h0, 3'b100);
        checks++; if (r_rdata !== 32'h000000CA || rsp_cyc != 3) begin errors++; $display("FAIL b2b_lbu got %h cyc=%0d want 000000ca 3", r_rdata, rsp_cyc); end
        run(1'b1, 32'h100, 32'h0000005A, 3'b000);
        run(1'b0, 32'h100, 32'h0, 3'b000);
        checks++; if (r_rdata !== 32'h0000005A) begin errors++; $display("FAIL b2b_sb_lb got %h want 0000005a", r_rdata); end
    endtask
    task automatic test_reset_mid();
        io.req_valid = 1'b1; io.req_we = 1'b1; io.req_addr = 32'h102; io.req_wdata = 32'hDEADBEEF; io.req_funct3 = 3'b010;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (io.mem_en !== 1'b1 || io.mem_we !== 1'b1 || io.mem_addr !== 32'h104) begin errors++; $display("FAIL mid_acc1 got en=%b we=%b addr=%h want 1 1 00000104", io.mem_en, io.mem_we, io.mem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (io.mem_en !== 1'b0 || io.mem_we !== 1'b0 || io.mem_wstrb !== 4'b0 || io.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_abort got en=%b we=%b strb=%b rv=%b want 0 0 0000 0", io.mem_en, io.mem_we, io.mem_wstrb, io.rsp_valid); end
        io.req_valid = 1'b0;
        #1;
        checks++; if (io.stall !== 1'b0) begin errors++; $display("FAIL mid_stall got %b want 0", io.stall); end
        @(negedge clk);
        rst = 1'b1;
        mem[64] = 32'h7F000000;
        run(1'b0, 32'h103, 32'h0, 3'b000);
        checks++; if (r_rdata !== 32'h0000007F || rsp_cyc != 3 || r_err !== 1'b0) begin errors++; $display("FAIL mid_lb got %h cyc=%0d err=%b want 0000007f 3 0", r_rdata, rsp_cyc, r_err); end
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        io.req_valid = 1'b0; io.req_we = 1'b0; io.req_addr = '0; io.req_wdata = '0; io.req_funct3 = '0;
        io2.req_valid = 1'b0; io2.req_we = 1'b0; io2.req_addr = '0; io2.req_wdata = '0; io2.req_funct3 = '0;
        io2.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_load_aligned();
        test_load_ext();
        test_load_cross();
        test_store_cross();
        test_store_wrap();
        test_error();
        test_no_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
